// File: rtl/lvc_ahb_pkg.sv
// rtl/lvc_ahb_pkg.sv - shared lvc_ahb encodings plus arbiter state and burst-length helper
package lvc_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } trans_type_enum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } burst_type_enum;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } response_type_enum;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    BURST  = 2'd2,
    LOCKED = 2'd3
  } arb_state_enum;

  localparam int BEAT_CNT_W = 4;

  // Undefined-length INCR reports 0 so it never arms the beat counter.
  function automatic logic [4:0] burst_beats(burst_type_enum b);
    case (b)
      HBURST_SINGLE:                burst_beats = 5'd1;
      HBURST_INCR:                  burst_beats = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/lvc_ahb_arb_picker.sv
// rtl/lvc_ahb_arb_picker.sv - combinational one-hot next-winner selection
// LVC_AHB_ARB_FIXED_PRIO_EN selects lowest-index priority and drops the pointer input.
module lvc_ahb_arb_picker #(
  parameter int NUM_MST = 4,
  parameter int MST_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
  input  logic [MST_W-1:0]   ptr,
`endif
  output logic [NUM_MST-1:0] gnt,
  output logic [MST_W-1:0]   gnt_idx,
  output logic               any
);

`ifdef LVC_AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!any && req[MST_W'(i)]) begin
        any                = 1'b1;
        gnt[MST_W'(i)]     = 1'b1;
        gnt_idx            = MST_W'(i);
      end
    end
  end
`else
  int idx;

  // Search starts just after the last winner, so the last winner is checked last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_MST; i++) begin
      idx = (int'(ptr) + i) % NUM_MST;
      if (!any && req[MST_W'(idx)]) begin
        any              = 1'b1;
        gnt[MST_W'(idx)] = 1'b1;
        gnt_idx          = MST_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/lvc_ahb_arbiter.sv
// rtl/lvc_ahb_arbiter.sv - lvc_ahb bus arbiter: burst/lock-safe handover, parks on DEFAULT_MST
// LVC_AHB_ARB_FIXED_PRIO_EN switches round-robin selection to fixed lowest-index priority.
module lvc_ahb_arbiter
  import lvc_ahb_pkg::*;
#(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0,
  parameter int MST_W       = $clog2(NUM_MST)
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MST_W-1:0]   hmaster,
  output logic               hmastlock
);

  localparam logic [NUM_MST-1:0] DEF_GNT = NUM_MST'(1) << DEFAULT_MST;
  localparam logic [MST_W-1:0]   DEF_IDX = MST_W'(DEFAULT_MST);

  arb_state_enum           state_q, state_d;
  logic [NUM_MST-1:0]      grant_q, grant_d;
  logic [MST_W-1:0]        gidx_q, gidx_d;
  logic [MST_W-1:0]        hmaster_q, hmaster_d;
  logic                    hmastlock_q, hmastlock_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    abort_q, abort_d;
  logic                    rel_q, rel_d;

  trans_type_enum          trans;
  burst_type_enum          burst;
  logic [4:0]              beats;
  logic                    fixed_burst;
  logic                    owner_lock;
  logic                    arb_ok;
  logic                    do_arb;

  logic [NUM_MST-1:0]      pick_gnt;
  logic [MST_W-1:0]        pick_idx;
  logic                    pick_any;

`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
  logic [MST_W-1:0]        ptr_q, ptr_d;
`endif

  lvc_ahb_arb_picker #(
    .NUM_MST (NUM_MST),
    .MST_W   (MST_W)
  ) u_picker (
    .req     (hbusreq),
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
    .ptr     (ptr_q),
`endif
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    trans       = trans_type_enum'(htrans);
    burst       = burst_type_enum'(hburst);
    beats       = burst_beats(burst);
    fixed_burst = (beats > 5'd1);
    owner_lock  = hlock[gidx_q];

    arb_ok = (state_q == PARK)
          || (trans == HTRANS_IDLE)
          || (((burst == HBURST_SINGLE) || (burst == HBURST_INCR))
              && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ))
              && (state_q != LOCKED))
          || ((state_q == BURST) && (trans == HTRANS_SEQ) && (cnt_q == BEAT_CNT_W'(1)))
          || abort_q;

    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    rel_d       = rel_q;
    do_arb      = 1'b0;
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    if (!hready) begin
      // First cycle of a two-cycle non-OKAY response: drop the burst so the
      // completing cycle becomes a handover point.
      if ((state_q == BURST) && (response_type_enum'(hresp) != HRESP_OKAY)) begin
        state_d = OWN;
        cnt_d   = '0;
        abort_d = 1'b1;
      end
    end else begin
      abort_d     = 1'b0;
      hmaster_d   = gidx_q;
      hmastlock_d = owner_lock;

      if (abort_q) begin
        cnt_d = '0;
      end else begin
        case (trans)
          HTRANS_NONSEQ: cnt_d = fixed_burst ? BEAT_CNT_W'(beats - 5'd1) : '0;
          HTRANS_SEQ:    cnt_d = (cnt_q != '0) ? cnt_q - BEAT_CNT_W'(1) : '0;
          HTRANS_IDLE:   cnt_d = '0;
          default:       cnt_d = cnt_q;
        endcase
      end

      if (state_q == LOCKED) begin
        // Keep the grant for one more ready cycle after hlock falls.
        if (owner_lock) begin
          rel_d = 1'b0;
        end else if (!rel_q) begin
          rel_d = 1'b1;
        end else begin
          do_arb = 1'b1;
        end
      end else if ((trans == HTRANS_NONSEQ) && fixed_burst && !abort_q) begin
        state_d = BURST;
      end else if (arb_ok) begin
        do_arb = 1'b1;
      end

      if (do_arb) begin
        rel_d = 1'b0;
        if (owner_lock) begin
          state_d = LOCKED;
        end else if (pick_any) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = OWN;
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
          ptr_d   = pick_idx;
`endif
        end else begin
          grant_d = DEF_GNT;
          gidx_d  = DEF_IDX;
          state_d = PARK;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= PARK;
      grant_q     <= DEF_GNT;
      gidx_q      <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      rel_q       <= 1'b0;
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
      ptr_q       <= DEF_IDX;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      rel_q       <= rel_d;
`ifndef LVC_AHB_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_lvc_ahb_arbiter.sv
// tb/tb_lvc_ahb_arbiter.sv - directed self-checking bench for lvc_ahb_arbiter
// Expectations follow LVC_AHB_ARB_FIXED_PRIO_EN where selection order differs.
module tb_lvc_ahb_arbiter;

  localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;
  localparam logic [1:0] R_OKAY = 2'd0, R_RETRY = 2'd2;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks   = 0;
  int failures = 0;

  lvc_ahb_arbiter u_dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
  endtask

  // M2 runs INCR8, drops its request at beat 2 while M3 starts requesting.
  task automatic burst8_handover(input bit stall, input int exp_edge, input string tag);
    int n;
    int hand;
    n    = 0;
    hand = 0;
    step(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq({tag, "_gnt_m2"}, 16'(hgrant), 16'h0004);
    step(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq({tag, "_hm_m2"}, 16'(hmaster), 16'd2);
    step(4'b0100, 4'b0000, T_NSEQ, B_INCR8, 1'b1, R_OKAY);
    for (int beat = 2; beat <= 8; beat++) begin
      if (stall && beat == 5) begin
        for (int s = 0; s < 2; s++) begin
          step(4'b1000, 4'b0000, T_SEQ, B_INCR8, 1'b0, R_OKAY);
          n++;
          if (hand == 0 && hgrant == 4'b1000) hand = n;
        end
      end
      step(4'b1000, 4'b0000, T_SEQ, B_INCR8, 1'b1, R_OKAY);
      n++;
      if (hand == 0 && hgrant == 4'b1000) hand = n;
    end
    check_eq({tag, "_handover_edge"}, 16'(hand), 16'(exp_edge));
    check_eq({tag, "_hm_last_beat"}, 16'(hmaster), 16'd2);
    step(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq({tag, "_gnt_m3"}, 16'(hgrant), 16'h0008);
    check_eq({tag, "_hm_m3"}, 16'(hmaster), 16'd3);
    idle_steps(2);
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq = '0; hlock = '0; htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1; hresp = R_OKAY;
    step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rst_gnt", 16'(hgrant), 16'h0001);
    check_eq("rst_hm", 16'(hmaster), 16'd0);
    check_eq("rst_ml", 16'(hmastlock), 16'd0);
    hresetn = 1'b1;

    // Parked with no requests
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
      check_eq($sformatf("park_gnt%0d", i), 16'(hgrant), 16'h0001);
      check_eq($sformatf("park_hm%0d", i), 16'(hmaster), 16'd0);
      check_eq($sformatf("park_ml%0d", i), 16'(hmastlock), 16'd0);
    end

    // M1 and M2 request together, single transfers
    step(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rr_gnt1", 16'(hgrant), 16'h0002);
    check_eq("rr_hm1", 16'(hmaster), 16'd0);
    step(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
`ifdef LVC_AHB_ARB_FIXED_PRIO_EN
    check_eq("rr_gnt2", 16'(hgrant), 16'h0002);
`else
    check_eq("rr_gnt2", 16'(hgrant), 16'h0004);
`endif
    check_eq("rr_hm2", 16'(hmaster), 16'd1);
    step(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rr_gnt3", 16'(hgrant), 16'h0002);
`ifdef LVC_AHB_ARB_FIXED_PRIO_EN
    check_eq("rr_hm3", 16'(hmaster), 16'd1);
`else
    check_eq("rr_hm3", 16'(hmaster), 16'd2);
`endif
    step(4'b0000, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rr_gnt_park", 16'(hgrant), 16'h0001);
    check_eq("rr_hm4", 16'(hmaster), 16'd1);
    step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rr_hm_park", 16'(hmaster), 16'd0);

    // INCR8 not broken; two-cycle stall delays handover by two edges
    burst8_handover(1'b0, 7, "b8");
    burst8_handover(1'b1, 9, "b8stall");

    // Locked sequence of three singles by M0, M1 waiting
    step(4'b0011, 4'b0001, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_gnt1", 16'(hgrant), 16'h0001);
    check_eq("lk_ml1", 16'(hmastlock), 16'd1);
    step(4'b0011, 4'b0001, T_NSEQ, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_gnt2", 16'(hgrant), 16'h0001);
    check_eq("lk_ml2", 16'(hmastlock), 16'd1);
    step(4'b0011, 4'b0001, T_NSEQ, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_gnt3", 16'(hgrant), 16'h0001);
    check_eq("lk_ml3", 16'(hmastlock), 16'd1);
    step(4'b0010, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_gnt_hold", 16'(hgrant), 16'h0001);
    check_eq("lk_ml_drop", 16'(hmastlock), 16'd0);
    step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_gnt_m1", 16'(hgrant), 16'h0002);
    step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("lk_hm_m1", 16'(hmaster), 16'd1);
    idle_steps(2);

    // M1 INCR16 retried at beat 5, M2 waiting
    step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("rt_gnt_m1", 16'(hgrant), 16'h0002);
    step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    step(4'b0010, 4'b0000, T_NSEQ, B_INCR16, 1'b1, R_OKAY);
    for (int b = 2; b <= 5; b++) begin
      step(4'b0100, 4'b0000, T_SEQ, B_INCR16, 1'b1, R_OKAY);
      check_eq($sformatf("rt_hold_b%0d", b), 16'(hgrant), 16'h0002);
    end
    step(4'b0100, 4'b0000, T_SEQ, B_INCR16, 1'b0, R_RETRY);
    check_eq("rt_gnt_stall", 16'(hgrant), 16'h0002);
    step(4'b0100, 4'b0000, T_SEQ, B_INCR16, 1'b1, R_RETRY);
    check_eq("rt_gnt_m2", 16'(hgrant), 16'h0004);
    idle_steps(2);

    // Reset in the middle of an M3 INCR4
    step(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    step(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
    check_eq("mr_hm_m3", 16'(hmaster), 16'd3);
    step(4'b1000, 4'b0000, T_NSEQ, B_INCR4, 1'b1, R_OKAY);
    step(4'b1000, 4'b0000, T_SEQ, B_INCR4, 1'b1, R_OKAY);
    hresetn = 1'b0;
    step(4'b1000, 4'b0000, T_SEQ, B_INCR4, 1'b1, R_OKAY);
    check_eq("mr_gnt", 16'(hgrant), 16'h0001);
    check_eq("mr_hm", 16'(hmaster), 16'd0);
    check_eq("mr_ml", 16'(hmastlock), 16'd0);
    hresetn = 1'b1;
    step(4'b0101, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
`ifdef LVC_AHB_ARB_FIXED_PRIO_EN
    check_eq("mr_ptr_gnt", 16'(hgrant), 16'h0001);
`else
    check_eq("mr_ptr_gnt", 16'(hgrant), 16'h0004);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvc_ahb_arbiter.md
Name: lvc_ahb_arbiter

Overview:
AHB bus arbiter for a multi-master lvc_ahb fabric.
- Samples per-master hbusreq/hlock and the muxed address-phase signals (htrans, hburst, hready, hresp).
- Drives one-hot hgrant, the hmaster index for the address/data muxes, and hmastlock.
- Never breaks fixed-length bursts or locked sequences.
- Parks the bus on a default master when idle.

Parameters:
- NUM_MST, 4, number of requesting masters (2..16).
- DEFAULT_MST, 0, park master when no request is pending.
- MST_W, $clog2(NUM_MST), width of hmaster (derived, not overridden).

Ports:
- hclk  input  1  bus clock, all logic on rising edge
- hresetn  input  1  synchronous active-low reset
- hbusreq  input  NUM_MST  per-master bus request
- hlock  input  NUM_MST  per-master lock request
- htrans  input  2  muxed transfer type of current address-phase owner
- hburst  input  3  muxed burst type of current address-phase owner
- hready  input  1  muxed slave ready
- hresp  input  2  muxed slave response
- hgrant  output  NUM_MST  one-hot grant
- hmaster  output  MST_W  index of current address-phase owner
- hmastlock  output  1  current address phase is locked

Behaviour:
- Clock and reset: one clock, hclk. Reset is synchronous and active-low on hresetn; all state is sampled at posedge hclk while hresetn==0.
- Reset values:
  - hgrant = one-hot(DEFAULT_MST).
  - hmaster = DEFAULT_MST.
  - hmastlock = 0.
  - RR pointer = DEFAULT_MST.
  - Beat counter = 0.
  - State = PARK.
- Handover rule: hgrant may change only at an edge with hready==1. hmaster and hmastlock take the new grant at the next edge with hready==1. So hmaster lags hgrant by exactly one hready-qualified cycle, and stalls hold both.
- Arbitration point (ARB_OK), true when any of the following holds:
  - State is PARK or IDLE-owned.
  - htrans==IDLE.
  - hburst is SINGLE or INCR and htrans is NONSEQ/SEQ, with no lock held.
  - The beat counter shows the final address beat of a fixed burst.
- Fixed bursts:
  - On NONSEQ with hready, load the counter with beats-1 (INCR4/WRAP4=3, 8-beat=7, 16-beat=15).
  - Decrement on each SEQ with hready.
  - BUSY holds the counter.
  - Counter==1 on the SEQ beat is the last-address-beat point; the grant may move for the following cycle.
- States:
  - PARK: no requests; default master granted.
  - OWN: master granted, no burst in progress.
  - BURST: fixed burst counting.
  - LOCKED: the granted master's hlock was sampled high with its grant. Hold the grant while hlock stays high, and until one further hready cycle after hlock drops (protects the final locked transfer).
- Transitions:
  - PARK -> OWN on any hbusreq.
  - OWN -> BURST on NONSEQ with a fixed hburst.
  - BURST -> OWN/PARK at the last beat.
  - Any state -> LOCKED when the owner's hlock is set at ARB_OK.
- Selection: round-robin. Start searching at pointer+1 mod NUM_MST. The winner is the first master with hbusreq set. The pointer updates to the winner on each hready-qualified handover. If the current owner still requests and no other master does, it keeps the grant.
- Error/retry: hresp in {ERROR, RETRY, SPLIT} with hready==0 (first response cycle) aborts BURST. The counter clears and the next hready edge is an ARB_OK point. A locked sequence stays LOCKED on ERROR.
- Requester drops hbusreq mid-burst: the burst still completes; the grant moves afterwards.
- Simultaneous requests: RR order decides. With no requests, the grant returns to DEFAULT_MST.
- Reset mid-burst: immediate return to reset values at the reset edge.

Optional Feature:
- Macro: LVC_AHB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The RR pointer is removed.
- Undefined: round-robin as above.
- Burst, lock and handover rules are identical in both modes.

Decomposition:
- lvc_ahb_pkg additions:
  - arb_state_enum {PARK, OWN, BURST, LOCKED}.
  - Function burst_beats(burst_type_enum) returning 1/4/8/16, with 0 for INCR (undefined length).
- Existing trans_type_enum, burst_type_enum and response_type_enum are reused for decoding.
- One sub-module, lvc_ahb_arb_picker: combinational one-hot next-winner selection from request vector and pointer, with fixed-priority under the macro.

Test Plan:
1. Reset, then no requests for 5 cycles -> hgrant=4'b0001, hmaster=0, hmastlock=0 throughout.
2. M1 and M2 request together, pointer=0, each doing SINGLE transfers -> grant order M1, M2, M1; hmaster follows each grant one hready cycle later.
3. M2 issues INCR8 while M3 requests from beat 2 -> M2 keeps hgrant for all 8 beats. hgrant moves to M3 at the beat-8 address cycle, with hmaster=3 on the next hready edge. Repeat with 2 hready=0 stall cycles mid-burst: handover delays by exactly 2 cycles.
4. M0 holds hlock for 3 SINGLE transfers while M1 requests -> hmastlock=1 for those 3 address phases. M1 is granted only one hready cycle after hlock drops.
5. M1 runs INCR16; the slave returns RETRY at beat 5 (hresp=RETRY, hready 0 then 1) -> burst aborted, rearbitration at that hready edge, and M2 (requesting) is granted.
6. Assert hresetn=0 mid-INCR4 -> at the next edge all outputs return to reset values. Under LVC_AHB_ARB_FIXED_PRIO_EN, scenario 2 grants M1 repeatedly while M1 keeps requesting.
